// File: rtl/shift_sequencer.sv
// Shift-register sequencer: clear, load from a/b, then N prescaled shift steps.
// Ports: clk, clr_n (async active-low reset); start/abort requests;
//   src_sel/mode/steps config (latched on start); sel1/sel2/func/load_n/clr
//   datapath controls; busy/done/aborted status; steps_left countdown.
module shift_sequencer #(
    parameter int unsigned TICK_DIV = 600,
    parameter int unsigned STEP_W   = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    input  logic              src_sel,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] steps,
    output logic              sel1,
    output logic              sel2,
    output logic [1:0]        func,
    output logic              load_n,
    output logic              clr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [15:0] PRESC_INIT = 16'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [15:0]       presc_q, presc_d;
    logic [STEP_W-1:0] sleft_q, sleft_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [1:0]        mode_q, mode_d;
    logic              src_q, src_d;
    logic              abrt_q, abrt_d;
    logic              go;
    logic              kill;

    // abort only terminates a live sequence; DONE completes regardless
    assign go   = (state_q == S_IDLE) && start && !abort;
    assign kill = abort && (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            sleft_q <= '0;
            steps_q <= '0;
            mode_q  <= '0;
            src_q   <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sleft_q <= sleft_d;
            steps_q <= steps_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            abrt_q  <= abrt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (go) state_d = S_CLEAR;
            S_CLEAR: state_d = S_LOAD;
            S_LOAD:  state_d = (steps_q == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (presc_q == '0) state_d = S_SHIFT;
            S_SHIFT: state_d = (sleft_q == STEP_W'(1)) ? S_DONE : S_WAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_comb begin
        src_d   = src_q;
        mode_d  = mode_q;
        steps_d = steps_q;
        if (go) begin
            src_d   = src_sel;
            mode_d  = mode;
            steps_d = steps;
        end
        // reload on WAIT entry, count down while staying in WAIT
        if (state_d == S_WAIT) begin
            presc_d = (state_q == S_WAIT) ? presc_q - 16'd1 : PRESC_INIT;
        end else begin
            presc_d = '0;
        end
        sleft_d = sleft_q;
        if (state_d == S_LOAD) sleft_d = steps_q;
        if (state_q == S_SHIFT) sleft_d = sleft_q - STEP_W'(1);
        if (kill) sleft_d = '0;
        abrt_d = kill;
    end

    always_comb begin
        sel1   = 1'b0;
        sel2   = 1'b0;
        func   = 2'b00;
        load_n = 1'b1;
        clr    = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_CLEAR: clr = 1'b1;
            S_LOAD: begin
                sel1   = src_q;
                load_n = 1'b0;
            end
            S_WAIT: begin
                sel1 = src_q;
                sel2 = 1'b1;
                func = mode_q;
            end
            S_SHIFT: begin
                sel1   = src_q;
                sel2   = 1'b1;
                func   = mode_q;
                load_n = 1'b0;
            end
            S_DONE: begin
                sel1 = src_q;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign aborted    = abrt_q;
    assign steps_left = sleft_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with TICK_DIV=4, STEP_W=4.
// Output bundle compared each cycle against hand-derived timing.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       src_sel = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] steps = 4'd0;
    logic       sel1, sel2, load_n, clr, busy, done, aborted;
    logic [1:0] func;
    logic [3:0] steps_left;

    int n_chk = 0;
    int n_pass = 0;

    shift_sequencer #(.TICK_DIV(4), .STEP_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .src_sel(src_sel), .mode(mode), .steps(steps),
        .sel1(sel1), .sel2(sel2), .func(func), .load_n(load_n),
        .clr(clr), .busy(busy), .done(done), .aborted(aborted),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    // bundle: {busy,done,aborted,clr,load_n,sel1,sel2,func,steps_left}
    function automatic logic [12:0] pk(bit b, bit d, bit a, bit cl,
                                       bit ln, bit s1, bit s2,
                                       logic [1:0] f, logic [3:0] sl);
        return {b, d, a, cl, ln, s1, s2, f, sl};
    endfunction

    localparam logic [12:0] IDLE_V = 13'b0_0_0_0_1_0_0_00_0000;

    function automatic logic [12:0] obs();
        return {busy, done, aborted, clr, load_n, sel1, sel2, func,
                steps_left};
    endfunction

    // expected bundle at cycle c of a sequence started at cycle 0
    // SHIFT k at 2+5k, done at 3+5n
    function automatic logic [12:0] exp_seq(int c, int n, bit src,
                                            logic [1:0] md);
        int k;
        if (c <= 0) return IDLE_V;
        if (c == 1) return pk(1, 0, 0, 1, 1, 0, 0, 2'b00, 4'd0);
        if (c == 2) return pk(1, 0, 0, 0, 0, src, 0, 2'b00, 4'(n));
        if (c == 3 + 5 * n) return pk(1, 1, 0, 0, 1, src, 0, 2'b00, 4'd0);
        if (c > 3 + 5 * n) return IDLE_V;
        k = (c - 2) / 5;
        if ((c - 2) % 5 == 0)
            return pk(1, 0, 0, 0, 0, src, 1, md, 4'(n - k + 1));
        return pk(1, 0, 0, 0, 1, src, 1, md, 4'(n - k));
    endfunction

    task automatic chk(input string tag, input logic [12:0] got,
                       input logic [12:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input bit s, input logic [1:0] m,
                        input logic [3:0] n);
        start   = 1'b1;
        src_sel = s;
        mode    = m;
        steps   = n;
    endtask

    initial begin
        #2 clr_n = 1'b0;
        #1 chk("reset", obs(), IDLE_V);
        #19 clr_n = 1'b1;
        step();
        chk("idle", obs(), IDLE_V);

        // main sequence, with ignored start at 5 and mode change at 6
        kick(1'b1, 2'b01, 4'd3);
        chk("A0", obs(), exp_seq(0, 3, 1'b1, 2'b01));
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) begin
                start = 1'b0; src_sel = 1'b0; mode = 2'b10; steps = 4'd7;
            end
            if (c == 5) start = 1'b1;
            if (c == 6) begin start = 1'b0; mode = 2'b11; end
            chk($sformatf("A%0d", c), obs(), exp_seq(c, 3, 1'b1, 2'b01));
        end

        // load only
        kick(1'b0, 2'b11, 4'd0);
        chk("B0", obs(), IDLE_V);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start = 1'b0;
            chk($sformatf("B%0d", c), obs(), exp_seq(c, 0, 1'b0, 2'b11));
        end

        // abort in WAIT at cycle 9
        kick(1'b1, 2'b01, 4'd3);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 9) abort = 1'b1;
            if (c == 10) abort = 1'b0;
            if (c < 10)
                chk($sformatf("C%0d", c), obs(),
                    exp_seq(c, 3, 1'b1, 2'b01));
            else if (c == 10)
                chk("C10", obs(), pk(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
            else
                chk($sformatf("C%0d", c), obs(), IDLE_V);
        end

        // abort in DONE: done pulses, no aborted
        kick(1'b1, 2'b10, 4'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start = 1'b0;
            abort = (c == 3);
            chk($sformatf("F%0d", c), obs(), exp_seq(c, 0, 1'b1, 2'b10));
        end
        abort = 1'b0;

        // start with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("E%0d", c), obs(), IDLE_V);
        end
        start = 1'b0;
        abort = 1'b0;

        // async reset mid-sequence, start on first post-reset edge
        kick(1'b1, 2'b01, 4'd3);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) start = 1'b0;
            chk($sformatf("D%0d", c), obs(), exp_seq(c, 3, 1'b1, 2'b01));
        end
        #2 clr_n = 1'b0;
        #1 chk("D_async", obs(), IDLE_V);
        kick(1'b0, 2'b10, 4'd1);
        step();
        chk("D_held", obs(), IDLE_V);
        @(negedge clk);
        clr_n = 1'b1;
        step();
        start = 1'b0;
        chk("D_clr", obs(), exp_seq(1, 1, 1'b0, 2'b10));
        for (int c = 2; c <= 10; c++) begin
            step();
            chk($sformatf("DR%0d", c), obs(), exp_seq(c, 1, 1'b0, 2'b10));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
